// File: rtl/telemetry_framer.sv
// Snapshots N sensor channels on request and streams them to the UART transmitter
// as a framed packet: SYNC, SEQ, LEN, big-endian payload, CHK (sum of SEQ..payload).
module telemetry_framer #(
  parameter int unsigned NUM_CHANNELS = 5,
  parameter int unsigned CHAN_WIDTH   = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                               sclk,
  input  logic                               rst,
  input  logic                               sampleValid,
  input  logic [NUM_CHANNELS*CHAN_WIDTH-1:0] chanData,
  input  logic                               uartReady,
  output logic                               dataReady,
  output logic [7:0]                         outByte,
  output logic                               busy,
  output logic                               frameDone,
  output logic [7:0]                         seqNum,
  output logic [7:0]                         overrunCount
);

  localparam int unsigned BPC      = (CHAN_WIDTH + 7) / 8;
  localparam int unsigned LEN      = NUM_CHANNELS * BPC;
  localparam logic [7:0]  LEN_BYTE = 8'(LEN);
  localparam logic [7:0]  LAST_IDX = 8'(LEN + 3);

  if (LEN > 250) begin : g_lenCheck
    $error("telemetry_framer: payload length exceeds 250 bytes");
  end
  if (NUM_CHANNELS < 1 || CHAN_WIDTH < 1 || CHAN_WIDTH > 32) begin : g_paramCheck
    $error("telemetry_framer: channel parameters out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW
  } framerState;

  framerState state, stateNext;

  logic [NUM_CHANNELS*CHAN_WIDTH-1:0] snapData;
  logic [7:0] snapSeq;
  logic [7:0] byteIdx;
  logic [7:0] chk;
  logic [7:0] curByte;
  logic [7:0] curPayload;
  logic [7:0] payload [LEN];
  logic       accept;
  logic       advance;
  logic       finish;

  // Each channel is zero-extended to whole bytes and laid out MSB byte first.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [BPC*8-1:0] padded;
    assign padded = (BPC*8)'(snapData[ch*CHAN_WIDTH +: CHAN_WIDTH]);
    for (genvar b = 0; b < BPC; b++) begin : g_byte
      assign payload[ch*BPC + b] = padded[(BPC-1-b)*8 +: 8];
    end
  end

  always_comb begin
    curPayload = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      if (32'(byteIdx) == i + 32'd3) curPayload = payload[i];
    end
  end

  always_comb begin
    if (byteIdx == 8'd0)          curByte = SYNC_BYTE;
    else if (byteIdx == 8'd1)     curByte = snapSeq;
    else if (byteIdx == 8'd2)     curByte = LEN_BYTE;
    else if (byteIdx == LAST_IDX) curByte = chk;
    else                          curByte = curPayload;
  end

  always_comb begin
    stateNext = state;
    dataReady = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (sampleValid) begin
          accept    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (uartReady) begin
          dataReady = 1'b1;
          stateNext = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // uartReady falling is the transmitter's acknowledgement of the byte.
        if (!uartReady) begin
          if (byteIdx == LAST_IDX) begin
            finish    = 1'b1;
            stateNext = IDLE;
          end else begin
            advance   = 1'b1;
            stateNext = ISSUE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign outByte = dataReady ? curByte : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      snapData     <= '0;
      snapSeq      <= '0;
      byteIdx      <= '0;
      chk          <= '0;
      seqNum       <= '0;
      overrunCount <= '0;
      frameDone    <= 1'b0;
    end else begin
      frameDone <= finish;
      if (accept) begin
        snapData <= chanData;
        snapSeq  <= seqNum;
        byteIdx  <= '0;
        chk      <= '0;
      end
      if (advance) byteIdx <= byteIdx + 8'd1;
      if (dataReady && byteIdx != 8'd0 && byteIdx != LAST_IDX) chk <= chk + curByte;
      if (finish) seqNum <= seqNum + 8'd1;
      if (sampleValid && busy && overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer (2 channels x 12 bits): transaction-level frame model
// checked every cycle, plus literal frame expectations for the directed scenarios.
module tb_telemetry_framer;

  localparam int unsigned NCH  = 2;
  localparam int unsigned CW   = 12;
  localparam int unsigned FLEN = 8;

  logic                sclk = 1'b0;
  logic                rst = 1'b1;
  logic                sampleValid = 1'b0;
  logic                uartReady = 1'b1;
  logic [NCH*CW-1:0]   chanData = '0;
  logic                dataReady;
  logic                busy;
  logic                frameDone;
  logic [7:0]          outByte;
  logic [7:0]          seqNum;
  logic [7:0]          overrunCount;

  int checks = 0;
  int failures = 0;
  logic [7:0] cap[$];

  telemetry_framer #(
    .NUM_CHANNELS(NCH),
    .CHAN_WIDTH(CW),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .sclk(sclk),
    .rst(rst),
    .sampleValid(sampleValid),
    .chanData(chanData),
    .uartReady(uartReady),
    .dataReady(dataReady),
    .outByte(outByte),
    .busy(busy),
    .frameDone(frameDone),
    .seqNum(seqNum),
    .overrunCount(overrunCount)
  );

  always #5 sclk = ~sclk;

  function automatic void chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Transmitter: takes a byte on dataReady, then is unavailable for 20 cycles.
  initial begin : xmtr
    forever begin
      @(negedge sclk);
      if (dataReady) begin
        cap.push_back(outByte);
        @(posedge sclk);
        #1 uartReady = 1'b0;
        repeat (20) @(posedge sclk);
        #1 uartReady = 1'b1;
      end
    end
  end

  // Reference model: a frame is a byte array built from the snapshot; the model
  // tracks which byte is owed and whether the transmitter has acknowledged it.
  initial begin : model
    bit live, mBusy, mAwait, mDone, prevDr, expDr;
    int mIdx, mSeq, mOvr, sum, v;
    logic [7:0] mFrame [FLEN];
    live = 0; mBusy = 0; mAwait = 0; mDone = 0; prevDr = 0;
    mIdx = 0; mSeq = 0; mOvr = 0;
    for (int k = 0; k < FLEN; k++) mFrame[k] = 8'h00;
    forever begin
      @(negedge sclk);
      if (live) begin
        expDr = mBusy && !mAwait && uartReady;
        chk("dataReady", 32'(dataReady), 32'(expDr));
        chk("outByte", 32'(outByte), expDr ? 32'(mFrame[mIdx]) : 32'd0);
        chk("busy", 32'(busy), 32'(mBusy));
        chk("frameDone", 32'(frameDone), 32'(mDone));
        chk("seqNum", 32'(seqNum), 32'(mSeq));
        chk("overrunCount", 32'(overrunCount), 32'(mOvr));
        chk("drSpacing", 32'(prevDr && dataReady), 32'd0);
      end
      prevDr = dataReady;
      if (rst) begin
        live = 1; mBusy = 0; mAwait = 0; mDone = 0; mIdx = 0; mSeq = 0; mOvr = 0;
      end else if (live) begin
        mDone = 0;
        if (!mBusy) begin
          if (sampleValid) begin
            mFrame[0] = 8'hA5;
            mFrame[1] = 8'(mSeq);
            mFrame[2] = 8'(NCH * 2);
            for (int c = 0; c < NCH; c++) begin
              v = int'(chanData >> (c * CW)) & 32'hFFF;
              mFrame[3 + 2*c] = 8'(v / 256);
              mFrame[4 + 2*c] = 8'(v % 256);
            end
            sum = 0;
            for (int k = 1; k < FLEN - 1; k++) sum += int'(mFrame[k]);
            mFrame[FLEN-1] = 8'(sum % 256);
            mBusy = 1; mIdx = 0; mAwait = 0;
          end
        end else begin
          if (sampleValid && mOvr < 255) mOvr++;
          if (!mAwait) begin
            mAwait = uartReady;
          end else if (!uartReady) begin
            mAwait = 0;
            if (mIdx == FLEN - 1) begin
              mBusy = 0; mDone = 1; mSeq = (mSeq + 1) % 256;
            end else begin
              mIdx++;
            end
          end
        end
      end
    end
  end

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      seen = frameDone;
    end
    chk({name, "_doneTimeout"}, 32'(seen), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      seen = !busy;
    end
    chk({name, "_idleTimeout"}, 32'(seen), 32'd1);
  endtask

  task automatic checkFrame(input string name, input int off, input logic [63:0] want);
    logic [31:0] act;
    for (int k = 0; k < FLEN; k++) begin
      act = (off + k < cap.size()) ? 32'(cap[off + k]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", name, k), act, 32'(want[63 - 8*k -: 8]));
    end
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin : main
    int frames;
    bit gotBytes;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_dataReady", 32'(dataReady), 32'd0);
    chk("rst_outByte", 32'(outByte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frameDone", 32'(frameDone), 32'd0);
    chk("rst_seqNum", 32'(seqNum), 32'd0);
    chk("rst_overrun", 32'(overrunCount), 32'd0);

    // Basic frame; chanData changes right after acceptance (snapshot).
    cap.delete();
    chanData = {12'h123, 12'hABC};
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    chanData = '1;
    chk("basic_busyAfterAccept", 32'(busy), 32'd1);
    waitDone("basic");
    checkFrame("basic", 0, 64'hA5_00_04_0A_BC_01_23_EE);
    chk("basic_seqNum", 32'(seqNum), 32'd1);

    // Three dropped requests during one frame.
    tick(3);
    cap.delete();
    chanData = (NCH*CW)'($urandom);
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick(30);
      sampleValid = 1'b1;
      tick(1);
      sampleValid = 1'b0;
    end
    waitDone("overrun3");
    tick(60);
    chk("overrun3_count", 32'(overrunCount), 32'd3);
    chk("overrun3_bytes", 32'(cap.size()), 32'd8);
    chk("overrun3_idle", 32'(busy), 32'd0);

    // Held request: hundreds of drops, counter saturates.
    sampleValid = 1'b1;
    tick(700);
    sampleValid = 1'b0;
    waitIdle("saturate");
    chk("overrun_saturated", 32'(overrunCount), 32'd255);

    // Back-to-back: request in the frameDone cycle.
    resetPulse();
    cap.delete();
    chanData = {12'h123, 12'hABC};
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    waitDone("b2b_first");
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    waitDone("b2b_second");
    chk("b2b_bytes", 32'(cap.size()), 32'd16);
    checkFrame("b2b_a", 0, 64'hA5_00_04_0A_BC_01_23_EE);
    checkFrame("b2b_b", 8, 64'hA5_01_04_0A_BC_01_23_EF);

    // Random requests and data; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      chanData = (NCH*CW)'($urandom);
      sampleValid = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    sampleValid = 1'b0;
    waitIdle("random");

    // Sequence wrap over 257 frames.
    resetPulse();
    chanData = (NCH*CW)'($urandom);
    sampleValid = 1'b1;
    frames = 0;
    for (int i = 0; i < 60000 && frames < 256; i++) begin
      tick(1);
      if (frameDone) frames++;
    end
    chk("wrap_frames", 32'(frames), 32'd256);
    cap.delete();
    tick(1);
    sampleValid = 1'b0;
    waitDone("wrap");
    chk("wrap_bytes", 32'(cap.size()), 32'd8);
    chk("wrap_seqByte", (cap.size() > 1) ? 32'(cap[1]) : 32'hFFFF_FFFF, 32'd0);
    chk("wrap_seqNum", 32'(seqNum), 32'd1);

    // Reset after the third byte of a frame.
    tick(2);
    cap.delete();
    chanData = {12'h800, 12'h0FF};
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    gotBytes = 0;
    for (int i = 0; i < 200 && !gotBytes; i++) begin
      tick(1);
      gotBytes = (cap.size() >= 3);
    end
    chk("midrst_threeBytes", 32'(gotBytes), 32'd1);
    tick(5);
    resetPulse();
    chk("midrst_dataReady", 32'(dataReady), 32'd0);
    chk("midrst_outByte", 32'(outByte), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frameDone", 32'(frameDone), 32'd0);
    chk("midrst_seqNum", 32'(seqNum), 32'd0);
    chk("midrst_overrun", 32'(overrunCount), 32'd0);
    tick(40);
    chk("midrst_noMoreBytes", 32'(cap.size()), 32'd3);
    cap.delete();
    sampleValid = 1'b1;
    tick(1);
    sampleValid = 1'b0;
    waitDone("midrst_next");
    checkFrame("midrst_next", 0, 64'hA5_00_04_00_FF_08_00_0B);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
